rv32i_lsu: RTL
==============

Name: rv32i_lsu

Overview:
Load/store unit for the multicycle RV32I core. It sits directly downstream of decode/execute and consumes the decoded memory-op, access-size and writeback-enable fields plus the ADD_MEM address result. It drives a single-outstanding data-memory request/grant/response bus. It returns aligned, sign- or zero-extended load data to the writeback stage, and it flags misaligned accesses without issuing any bus traffic.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data bus width; only 32 is supported

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  decoded memory op is presented
req_ready  out  1  LSU can accept an op (high only in IDLE)
mem_op  in  2  LOAD=00, STORE=01, MEM_NOOP=11 (shared package encoding)
mem_size  in  2  BYTE=00, HALF_WORD=01, WORD=10
mem_unsigned  in  1  1 = LBU/LHU zero-extend; ignored for stores and WORD
wb_req  in  1  WB_EN/WB_NOOP from decode
rd  in  5  destination register
addr  in  32  effective byte address
store_data  in  32  rs2 value
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_be  out  4  byte enables
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
wb_valid  out  1  one-cycle completion pulse
wb_en  out  1  register write requested with wb_valid
wb_rd  out  5  destination register
wb_data  out  32  extended load data
misaligned  out  1  one-cycle pulse, coincident with wb_valid
misaligned_addr  out  32  offending address

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0 except req_ready=1. Any in-flight request is abandoned and dmem_req drops immediately.
- Accept: req_valid & req_ready at a clock edge. At that edge, latch op, size, unsigned, wb_req, rd, addr[1:0] and the bus fields.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE -> DONE when the accepted op is MEM_NOOP or misaligned.
- IDLE -> REQ when the accepted op is an aligned LOAD or STORE.
- REQ: dmem_req=1 with stable address, we, be and wdata until dmem_gnt. On gnt: a store goes to DONE; a load goes to WAIT_RESP.
- WAIT_RESP: dmem_req=0. On dmem_rvalid, register the extracted/extended data and go to DONE.
- DONE: wb_valid=1 for exactly one cycle, then IDLE.
- wb_en values at DONE:
  - load: wb_req & (rd!=0)
  - store, MEM_NOOP, misaligned: 0
- Misaligned conditions: HALF with addr[0]=1; WORD with addr[1:0]!=0; size=11 is treated as misaligned. No bus request is issued. misaligned=1 and misaligned_addr=addr for the DONE cycle.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0]
  - HALF: 4'b0011<<addr[1:0]
  - WORD: 4'b1111
- Store wdata: BYTE replicates data[7:0] ×4; HALF replicates data[15:0] ×2; WORD passes through.
- Load extraction: select the byte or halfword at addr[1:0] of dmem_rdata. Sign-extend when mem_unsigned=0, otherwise zero-extend. WORD passes through.
- Latency from accept edge to wb_valid, assuming zero-wait gnt and rvalid the cycle after gnt:
  - load: 3 cycles
  - store: 2 cycles
  - MEM_NOOP or misaligned: 1 cycle
- Each extra gnt or rvalid wait cycle adds one cycle.
- Simultaneous events and stray inputs:
  - dmem_rvalid in any state except WAIT_RESP is ignored. This covers a stale response after reset.
  - dmem_gnt outside REQ is ignored.
  - req_valid while busy is not accepted. Upstream must hold it.
- wb_data holds its last load value when no load completes. wb_rd is registered from the accepted rd.

Decomposition:
- Add to the shared RV32I core package:
  - the lsu_state_t enum (IDLE, REQ, WAIT_RESP, DONE)
  - MEM_LOAD_UNSIGNED flag semantics
  - byte-enable constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111
- The existing LOAD/STORE/MEM_NOOP and BYTE/HALF_WORD/WORD encodings are reused unchanged.
- One combinational sub-module, rv32i_load_align, takes rdata, addr[1:0], size and unsigned, and returns the 32-bit extended result.

Test Plan:
- LB from addr 0x1003 with rdata 0x80FF_1234, unsigned=0, rd=5, wb_req=1 -> dmem_addr=0x1000, be=4'b1000. wb_valid fires 3 cycles after accept with wb_en=1, wb_rd=5, wb_data=0xFFFF_FF80.
- LHU from addr 0x2002 with rdata 0x9ABC_0000 -> be=4'b1100, wb_data=0x0000_9ABC. The same access with unsigned=0 gives 0xFFFF_9ABC.
- SB to addr 0x3001 with store_data 0x1234_56A5, gnt delayed 2 cycles:
  - dmem_req is held 3 cycles with be=4'b0010, we=1, wdata=0xA5A5_A5A5.
  - wb_valid follows 1 cycle after gnt with wb_en=0.
- LW from addr 0x4002 -> no dmem_req. The next cycle gives wb_valid=1, misaligned=1, misaligned_addr=0x4002, wb_en=0.
- MEM_NOOP with wb_req=1 -> wb_valid 1 cycle later with wb_en=0 and no bus activity. A LW with rd=0 and rdata 0xDEAD_BEEF completes with wb_en=0.
- rst_n is asserted low while in WAIT_RESP, then released; a stray dmem_rvalid arrives afterwards -> dmem_req=0 and state=IDLE immediately, no wb_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/rv32i_lsu_pkg.sv
// Shared RV32I core definitions used by the load/store unit: memory-op and
// access-size encodings, byte-enable constants, LSU FSM states and helpers.
package rv32i_lsu_pkg;

    // Memory operation encoding from decode.
    localparam logic [1:0] LOAD      = 2'b00;
    localparam logic [1:0] STORE     = 2'b01;
    localparam logic [1:0] MEM_NOOP  = 2'b11;

    // Access size encoding from decode.
    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    // mem_unsigned flag: set for LBU/LHU (zero-extend), clear for LB/LH.
    localparam logic MEM_LOAD_UNSIGNED = 1'b1;
    localparam logic MEM_LOAD_SIGNED   = 1'b0;

    // Byte-enable patterns for lane 0; shifted left by the byte offset.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQ       = 2'b01,
        WAIT_RESP = 2'b10,
        DONE      = 2'b11
    } lsu_state_t;

    // Reserved size 2'b11 is reported as misaligned so it never reaches the bus.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            BYTE:      r = 1'b0;
            HALF_WORD: r = off[0];
            WORD:      r = (off != 2'b00);
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lsu_byte_enable(input logic [1:0] size,
                                                   input logic [1:0] off);
        logic [3:0] r;
        case (size)
            BYTE:      r = BE_BYTE << off;
            HALF_WORD: r = BE_HALF << off;
            default:   r = BE_WORD;
        endcase
        return r;
    endfunction

    // Replicate store data across all lanes so the byte enables pick the right one.
    function automatic logic [31:0] lsu_store_lanes(input logic [1:0] size,
                                                    input logic [31:0] data);
        logic [31:0] r;
        case (size)
            BYTE:      r = {4{data[7:0]}};
            HALF_WORD: r = {2{data[15:0]}};
            default:   r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Extracts the addressed byte/halfword from a 32-bit read word and
// sign- or zero-extends it to 32 bits. Words pass through unchanged.
module rv32i_load_align
    import rv32i_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    // Lane selection followed by extension according to size and signedness.
    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        // Halfword accesses are always aligned here, so only off[1] matters.
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_sign = 1'b0;
        o_data = i_rdata;
        case (i_size)
            BYTE: begin
                w_sign = (i_unsigned != MEM_LOAD_UNSIGNED) & w_byte[7];
                o_data = {{24{w_sign}}, w_byte};
            end
            HALF_WORD: begin
                w_sign = (i_unsigned != MEM_LOAD_UNSIGNED) & w_half[15];
                o_data = {{16{w_sign}}, w_half};
            end
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// Load/store unit: accepts one decoded memory op at a time, drives a single
// outstanding request/grant/response data bus, and returns extended load data
// to writeback. Misaligned accesses and MEM_NOOP complete without bus traffic.
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        mem_op,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic              wb_req,
    input  logic [4:0]        rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misaligned,
    output logic [ADDR_W-1:0] misaligned_addr
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_d;

    logic [1:0]        r_op;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [4:0]        r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_wdata;
    logic              r_misaligned;
    logic              r_wb_en;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_mis_in;
    logic [DATA_W-1:0] w_load_data;

    assign w_accept = req_valid & (r_state == IDLE);
    // Any op other than LOAD/STORE (including the unused 2'b10) behaves as MEM_NOOP.
    assign w_is_mem = (mem_op == LOAD) | (mem_op == STORE);
    assign w_mis_in = w_is_mem & lsu_misaligned(mem_size, addr[1:0]);

    assign dmem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = r_wdata;
    assign wb_rd      = r_rd;
    assign wb_data    = r_wb_data;

    rv32i_load_align u_load_align (
        .i_rdata    (dmem_rdata),
        .i_off      (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // FSM state register; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and bus/writeback outputs, all decoded from the current state.
    always_comb begin
        w_state_d       = r_state;
        req_ready       = 1'b0;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        dmem_be         = 4'b0000;
        wb_valid        = 1'b0;
        wb_en           = 1'b0;
        misaligned      = 1'b0;
        misaligned_addr = '0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_d = (w_is_mem && !w_mis_in) ? REQ : DONE;
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                dmem_we  = (r_op == STORE);
                dmem_be  = r_be;
                if (dmem_gnt) begin
                    w_state_d = (r_op == STORE) ? DONE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (dmem_rvalid) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                wb_valid   = 1'b1;
                wb_en      = r_wb_en;
                misaligned = r_misaligned;
                if (r_misaligned) begin
                    misaligned_addr = r_addr;
                end
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Capture the op fields and precomputed bus fields on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= MEM_NOOP;
            r_size       <= BYTE;
            r_unsigned   <= 1'b0;
            r_rd         <= 5'd0;
            r_addr       <= '0;
            r_be         <= 4'b0000;
            r_wdata      <= '0;
            r_misaligned <= 1'b0;
            r_wb_en      <= 1'b0;
        end else if (w_accept) begin
            r_op         <= mem_op;
            r_size       <= mem_size;
            r_unsigned   <= mem_unsigned;
            r_rd         <= rd;
            r_addr       <= addr;
            r_be         <= lsu_byte_enable(mem_size, addr[1:0]);
            r_wdata      <= lsu_store_lanes(mem_size, store_data);
            r_misaligned <= w_mis_in;
            // Only an aligned load to a non-zero register writes back.
            r_wb_en      <= (mem_op == LOAD) & ~w_mis_in & wb_req & (rd != 5'd0);
        end
    end

    // Load result register; holds its value until the next load response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_data <= '0;
        end else if ((r_state == WAIT_RESP) && dmem_rvalid) begin
            r_wb_data <= w_load_data;
        end
    end

endmodule
